perceptron_trainer: RTL and testbench
=====================================

# perceptron_trainer

Training (backward) side of the single-layer perceptron: owns the N 32-bit signed weight registers and drives them as a flat bus into the weighted-sum datapath. For each training sample it takes the input vector, the weighted sum computed for it, and the target label. It then applies the perceptron learning rule, sequentially updating one weight per cycle. It reports completion and keeps a running mistake count.

## Interface

- `N`, 8: number of inputs/weights.
- `STEP`, 32'd16: learning-rate increment added to or subtracted from each active weight on a mistake (32-bit, treated as unsigned magnitude).
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `x` input N: binary input vector of the sample; sampled on accept.
- `sum` input 32: signed weighted sum for `x` under the current weights; sampled on accept.
- `target` input 1: desired perceptron output; sampled on accept.
- `train_valid` input 1: sample present on `x`/`sum`/`target`.
- `train_ready` output 1: high only in IDLE; accept = `train_valid && train_ready`.
- `w` output 32*N: weight bus; weight i on bits [32*(i+1)-1:32*i], two's complement.
- `done` output 1: one-cycle pulse when the sample's processing completes.
- `mistake` output 1: valid while `done` is high; 1 if the prediction was wrong.
- `mistake_count` output 16: mistakes since reset, saturates at 16'hFFFF.

## Operation

- States: IDLE, EVAL, UPDATE, DONE. State, index, latched sample and all outputs are registered.
- IDLE: `train_ready`=1. On accept, latch `x`, `sum` and `target`, then go to EVAL. `train_valid` in any other state is ignored; nothing is latched.
- EVAL: prediction y = 1 iff $signed(sum_latched) > 0 (sum of 0 predicts 0).
  - err = target - y, in {-1, 0, +1}; stored as a mistake flag plus sign.
  - err = 0: go to DONE.
  - err ≠ 0: clear index i to 0, increment `mistake_count` unless it is saturated, go to UPDATE.
- UPDATE: one weight per cycle, i = 0..N-1.
  - If x_latched[i]=1: w[i] ← w[i] + STEP when err=+1, or w[i] − STEP when err=−1. Otherwise w[i] is unchanged.
  - After i = N-1, go to DONE.
- DONE: `done`=1; `mistake` = stored mistake flag; next state is IDLE.
- Arithmetic: 32-bit signed. Overflow handling is set by the configuration macro.
- `w` changes during UPDATE. The consumer must not present a new sample's `sum` until after `done`.
- Reset: state→IDLE, all weights 0, `mistake_count`=0, `done`=0, `mistake`=0, `train_ready`=1 in the first cycle after `rst` is sampled high.
- Reset mid-operation aborts the sample. Partial updates are discarded because all weights clear.

## Timing

- Accept on edge T0; EVAL during cycle T0+1.
- No mistake: DONE during T0+2; `train_ready` high again at T0+3.
- Mistake: UPDATE during T0+2 .. T0+N+1; w[i] holds its new value from T0+3+i; DONE during T0+N+2; `train_ready` high at T0+N+3.
- Back-to-back: a sample can be accepted in the first IDLE cycle after DONE.
- `mistake_count` increments on the EVAL→UPDATE edge, so it is visible from T0+2.

## Configuration

- `PERCEPTRON_TRAINER_SAT_EN` defined: each weight update saturates to 32'h7FFFFFFF (positive overflow) or 32'h80000000 (negative overflow).
- Not defined: updates wrap modulo 2^32.
- All other behaviour is identical in both builds.

## Test plan

- Reset: assert `rst` for 2 cycles → all `w`=0, `train_ready`=1, `done`=0, `mistake_count`=0.
- Positive mistake: x=8'b00000101, sum=0, target=1 → `done` at T0+10 with `mistake`=1; w0=16, w2=16, other weights 0; `mistake_count`=1.
- Correct prediction: x=8'hFF, sum=32'd5, target=1 → `done` at T0+2 with `mistake`=0; weights and `mistake_count` unchanged.
- Negative mistake: x=8'h80, sum=32'd5, target=0 → w7=32'hFFFFFFF0; `train_valid` held high throughout is not re-accepted until T0+11.
- Overflow, with STEP=32'h7FFFFFF0 and two mistakes on x=8'h01 (sum=0, target=1):
  - With `PERCEPTRON_TRAINER_SAT_EN`: w0=32'h7FFFFFFF.
  - Without it: w0=32'hFFFFFFE0.
- Reset mid-UPDATE: assert `rst` at T0+4 → next cycle shows IDLE, all weights 0, no `done` pulse, `mistake_count`=0.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - training sample handshake and completion signals
interface perceptron_trainer_if #(
  parameter int N = 8
);
  logic [N-1:0] x;
  logic [31:0]  sum;
  logic         target;
  logic         train_valid;
  logic         train_ready;
  logic         done;
  logic         mistake;

  modport master (
    output x, sum, target, train_valid,
    input  train_ready, done, mistake
  );

  modport slave (
    input  x, sum, target, train_valid,
    output train_ready, done, mistake
  );
endinterface

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - perceptron learning-rule weight updater; PERCEPTRON_TRAINER_SAT_EN selects saturating updates
module perceptron_trainer #(
  parameter int          N    = 8,
  parameter logic [31:0] STEP = 32'd16
) (
  input  logic                 clk,
  input  logic                 rst,
  perceptron_trainer_if.slave  tif,
  output logic [32*N-1:0]      w,
  output logic [15:0]          mistake_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [N-1:0]    x_q;
  logic [31:0]     sum_q;
  logic            tgt_q;
  logic            err_neg_q;
  logic [31:0]     w_q [N];
  logic [15:0]     cnt_q;
  logic            ready_q;
  logic            done_q;
  logic            mistake_q;

  logic [31:0]     w_cur;
  logic [31:0]     upd_d;
  logic            pred;

  assign pred = ($signed(sum_q) > 32'sd0);

`ifdef PERCEPTRON_TRAINER_SAT_EN
  logic [33:0]     ext_d;

  // Widened add/subtract of the selected weight, clamped to the signed 32-bit range
  always_comb begin
    w_cur = w_q[idx_q];
    if (err_neg_q) ext_d = {{2{w_cur[31]}}, w_cur} - {2'b00, STEP};
    else           ext_d = {{2{w_cur[31]}}, w_cur} + {2'b00, STEP};
    if (ext_d[33:31] == 3'b000 || ext_d[33:31] == 3'b111) upd_d = ext_d[31:0];
    else if (ext_d[33])                                   upd_d = 32'h8000_0000;
    else                                                  upd_d = 32'h7FFF_FFFF;
  end
`else
  // Wrapping add/subtract of the selected weight
  always_comb begin
    w_cur = w_q[idx_q];
    if (err_neg_q) upd_d = w_cur - STEP;
    else           upd_d = w_cur + STEP;
  end
`endif

  // Training FSM: latch sample, evaluate prediction, walk the weights, report
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      sum_q     <= '0;
      tgt_q     <= 1'b0;
      err_neg_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      mistake_q <= 1'b0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tif.train_valid) begin
            x_q     <= tif.x;
            sum_q   <= tif.sum;
            tgt_q   <= tif.target;
            ready_q <= 1'b0;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          if (tgt_q == pred) begin
            done_q    <= 1'b1;
            mistake_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            // target=1 with prediction 0 raises weights; target=0 with prediction 1 lowers them
            err_neg_q <= ~tgt_q;
            idx_q     <= '0;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            state_q   <= UPDATE;
          end
        end
        UPDATE: begin
          if (x_q[idx_q]) w_q[idx_q] <= upd_d;
          if (idx_q == IW'(N - 1)) begin
            done_q    <= 1'b1;
            mistake_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          done_q    <= 1'b0;
          mistake_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Flatten weight registers onto the output bus
  always_comb begin
    w = '0;
    for (int i = 0; i < N; i++) w[32*i +: 32] = w_q[i];
  end

  assign mistake_count   = cnt_q;
  assign tif.train_ready = ready_q;
  assign tif.done        = done_q;
  assign tif.mistake     = mistake_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - directed self-checking bench for perceptron_trainer
module tb_perceptron_trainer;

  logic            clk;
  logic            rst;
  logic [255:0]    w0_bus;
  logic [255:0]    w1_bus;
  logic [15:0]     cnt0;
  logic [15:0]     cnt1;
  int              n_checks;
  int              n_err;

  perceptron_trainer_if #(.N(8)) if0 ();
  perceptron_trainer_if #(.N(8)) if1 ();

  perceptron_trainer #(.N(8), .STEP(32'd16)) dut (
    .clk           (clk),
    .rst           (rst),
    .tif           (if0.slave),
    .w             (w0_bus),
    .mistake_count (cnt0)
  );

  perceptron_trainer #(.N(8), .STEP(32'h7FFF_FFF0)) dut_ov (
    .clk           (clk),
    .rst           (rst),
    .tif           (if1.slave),
    .w             (w1_bus),
    .mistake_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [255:0] bus, input int i);
    return bus[32*i +: 32];
  endfunction

  // Present one sample on if0, wait for done, return cycles after accept edge
  task automatic send0(input logic [7:0] xv, input logic [31:0] sv, input logic tv,
                       output int lat, output logic mis);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!if0.train_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if0.x = xv;
    if0.sum = sv;
    if0.target = tv;
    if0.train_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.train_valid = 1'b0;
    lat = 0;
    mis = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (if0.done) begin
        lat = k;
        mis = if0.mistake;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Present one sample on if1 and wait for its done pulse
  task automatic send1(input logic [7:0] xv, input logic [31:0] sv, input logic tv,
                       output logic mis);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!if1.train_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if1.x = xv;
    if1.sum = sv;
    if1.target = tv;
    if1.train_valid = 1'b1;
    @(negedge clk);
    if1.train_valid = 1'b0;
    mis = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (if1.done) begin
        mis = if1.mistake;
        break;
      end
      @(negedge clk);
    end
  endtask

  int   lat;
  logic mis;
  int   busy;
  int   done_seen;
  int   done_at;

  initial begin
    n_checks = 0;
    n_err = 0;
    if0.x = '0; if0.sum = '0; if0.target = 1'b0; if0.train_valid = 1'b0;
    if1.x = '0; if1.sum = '0; if1.target = 1'b0; if1.train_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) check($sformatf("rst_w%0d", i), wsel(w0_bus, i), 32'd0);
    check("rst_ready", {31'd0, if0.train_ready}, 32'd1);
    check("rst_done", {31'd0, if0.done}, 32'd0);
    check("rst_cnt", {16'd0, cnt0}, 32'd0);

    // Positive mistake: x=0b101, sum=0, target=1
    send0(8'b0000_0101, 32'd0, 1'b1, lat, mis);
    check("pos_lat", lat, 32'd10);
    check("pos_mis", {31'd0, mis}, 32'd1);
    check("pos_w0", wsel(w0_bus, 0), 32'd16);
    check("pos_w1", wsel(w0_bus, 1), 32'd0);
    check("pos_w2", wsel(w0_bus, 2), 32'd16);
    check("pos_w7", wsel(w0_bus, 7), 32'd0);
    check("pos_cnt", {16'd0, cnt0}, 32'd1);

    // Correct prediction: positive sum, target=1
    send0(8'hFF, 32'd5, 1'b1, lat, mis);
    check("ok_lat", lat, 32'd2);
    check("ok_mis", {31'd0, mis}, 32'd0);
    check("ok_w0", wsel(w0_bus, 0), 32'd16);
    check("ok_w3", wsel(w0_bus, 3), 32'd0);
    check("ok_cnt", {16'd0, cnt0}, 32'd1);

    // Correct prediction with negative sum, target=0
    send0(8'h03, 32'hFFFF_FFFF, 1'b0, lat, mis);
    check("negsum_lat", lat, 32'd2);
    check("negsum_mis", {31'd0, mis}, 32'd0);

    // Zero sum predicts 0: target=0 is correct
    send0(8'h0F, 32'd0, 1'b0, lat, mis);
    check("zero_lat", lat, 32'd2);
    check("zero_cnt", {16'd0, cnt0}, 32'd1);

    // Negative mistake with train_valid held high throughout
    @(negedge clk);
    if0.x = 8'h80;
    if0.sum = 32'd5;
    if0.target = 1'b0;
    if0.train_valid = 1'b1;
    @(posedge clk);
    busy = 0;
    done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!if0.train_ready) busy++;
      if (if0.done && done_at == 0) done_at = k;
    end
    @(negedge clk);
    check("neg_busy", busy, 32'd10);
    check("neg_done_at", done_at, 32'd10);
    check("neg_ready_t11", {31'd0, if0.train_ready}, 32'd1);
    if0.train_valid = 1'b0;
    check("neg_w7", wsel(w0_bus, 7), 32'hFFFF_FFF0);
    check("neg_w0", wsel(w0_bus, 0), 32'd16);
    check("neg_cnt", {16'd0, cnt0}, 32'd2);

    // Most negative sum predicts 0: target=1 is a mistake, raises w1
    send0(8'h02, 32'h8000_0000, 1'b1, lat, mis);
    check("minsum_mis", {31'd0, mis}, 32'd1);
    check("minsum_w1", wsel(w0_bus, 1), 32'd16);
    check("minsum_cnt", {16'd0, cnt0}, 32'd3);

    // Reset during UPDATE
    @(negedge clk);
    if0.x = 8'hFF;
    if0.sum = 32'd0;
    if0.target = 1'b1;
    if0.train_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.train_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_ready", {31'd0, if0.train_ready}, 32'd1);
    check("mid_done", {31'd0, if0.done}, 32'd0);
    check("mid_cnt", {16'd0, cnt0}, 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("mid_w%0d", i), wsel(w0_bus, i), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if0.done) done_seen++;
    end
    check("mid_no_done", done_seen, 32'd0);

    // Overflow with large STEP: two positive mistakes on x=0x01
    send1(8'h01, 32'd0, 1'b1, mis);
    check("ov1_mis", {31'd0, mis}, 32'd1);
    check("ov1_w0", wsel(w1_bus, 0), 32'h7FFF_FFF0);
    send1(8'h01, 32'd0, 1'b1, mis);
    check("ov2_mis", {31'd0, mis}, 32'd1);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    check("ov2_w0", wsel(w1_bus, 0), 32'h7FFF_FFFF);
`else
    check("ov2_w0", wsel(w1_bus, 0), 32'hFFFF_FFE0);
`endif
    check("ov2_w1", wsel(w1_bus, 1), 32'd0);
    check("ov2_cnt", {16'd0, cnt1}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
